// File: rtl/stackcalc_ctrl.sv
// Command sequencer for the nibble-driven stack calculator.
// TOS lives in a register, deeper entries in an external sync single-port RAM.
module stackcalc_ctrl #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] cmd,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    output logic [AW-1:0]     mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] tos,
    output logic [AW:0]       depth,
    output logic              err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, OPND, RD, EX} state_t;

    localparam logic [3:0] OP_PUSH = 4'h1;
    localparam logic [3:0] OP_DROP = 4'h2;
    localparam logic [3:0] OP_DUP  = 4'h3;
    localparam logic [3:0] OP_SWAP = 4'h4;
    localparam logic [3:0] OP_ADD  = 4'h5;
    localparam logic [3:0] OP_SUB  = 4'h6;
    localparam logic [3:0] OP_AND  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_NOT  = 4'hA;
    localparam logic [3:0] OP_CLR  = 4'hB;

    localparam logic [AW:0] ONE  = (AW+1)'(1);
    localparam logic [AW:0] TWO  = (AW+1)'(2);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] tos_q, tos_d;
    logic [AW:0]       depth_q, depth_d;
    logic              err_q, err_d;
    logic [3:0]        op_q, op_d;

    logic              xfer;
    logic              is_empty, has_two, is_full;
    logic [AW:0]       dm1, dm2;
    logic [AW-1:0]     top_addr, nos_addr;
    logic              we_w;
    logic [AW-1:0]     addr_w;
    logic [DATA_W-1:0] wdata_w;

    assign cmd_ready = (state_q == IDLE) || (state_q == OPND);
    assign busy      = (state_q == RD) || (state_q == EX);
    assign xfer      = cmd_valid && cmd_ready;

    assign is_empty = (depth_q == '0);
    assign has_two  = (depth_q >= TWO);
    assign is_full  = (depth_q == FULL);

    // Spill slot is depth-1, next-on-stack is depth-2.
    assign dm1      = depth_q - ONE;
    assign dm2      = depth_q - TWO;
    assign top_addr = dm1[AW-1:0];
    assign nos_addr = dm2[AW-1:0];

    always_comb begin
        state_d = state_q;
        tos_d   = tos_q;
        depth_d = depth_q;
        err_d   = err_q;
        op_d    = op_q;
        we_w    = 1'b0;
        addr_w  = nos_addr;
        wdata_w = tos_q;
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    op_d = cmd[3:0];
                    case (cmd[3:0])
                        OP_PUSH: state_d = OPND;
                        OP_DROP: begin
                            if (is_empty) begin
                                err_d = 1'b1;
                            end else if (depth_q == ONE) begin
                                tos_d   = '0;
                                depth_d = '0;
                            end else begin
                                state_d = RD;
                            end
                        end
                        OP_DUP: begin
                            if (is_empty || is_full) begin
                                err_d = 1'b1;
                            end else begin
                                we_w    = 1'b1;
                                addr_w  = top_addr;
                                depth_d = depth_q + ONE;
                            end
                        end
                        OP_SWAP, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                            if (!has_two) err_d = 1'b1;
                            else          state_d = RD;
                        end
                        OP_NOT: begin
                            if (is_empty) err_d = 1'b1;
                            else          tos_d = ~tos_q;
                        end
                        OP_CLR: begin
                            tos_d   = '0;
                            depth_d = '0;
                            err_d   = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            OPND: begin
                if (xfer) begin
                    state_d = IDLE;
                    if (is_full) begin
                        err_d = 1'b1;
                    end else begin
                        we_w    = !is_empty;
                        addr_w  = top_addr;
                        tos_d   = cmd;
                        depth_d = depth_q + ONE;
                    end
                end
            end
            RD: state_d = EX;
            EX: begin
                state_d = IDLE;
                depth_d = depth_q - ONE;
                case (op_q)
                    OP_DROP: tos_d = mem_rdata;
                    OP_SWAP: begin
                        we_w    = 1'b1;
                        tos_d   = mem_rdata;
                        depth_d = depth_q;
                    end
                    OP_ADD:  tos_d = mem_rdata + tos_q;
                    OP_SUB:  tos_d = mem_rdata - tos_q;
                    OP_AND:  tos_d = mem_rdata & tos_q;
                    OP_OR:   tos_d = mem_rdata | tos_q;
                    OP_XOR:  tos_d = mem_rdata ^ tos_q;
                    default: depth_d = depth_q;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset aborts an op in flight, so no write may leak out that cycle.
    assign mem_we    = we_w && rst;
    assign mem_addr  = addr_w;
    assign mem_wdata = wdata_w;
    assign tos       = tos_q;
    assign depth     = depth_q;
    assign err       = err_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            tos_q   <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            tos_q   <= tos_d;
            depth_q <= depth_d;
            err_q   <= err_d;
            op_q    <= op_d;
        end
    end

endmodule
